// File: rtl/column_frame_scheduler_if.sv
// Avalon-MM slave bundle for the column frame scheduler: chip select, write strobe,
// one-bit address, 16-bit write data and the waitrequest stall.
interface column_frame_scheduler_if;
  logic        chipselect;
  logic        write;
  logic        address;
  logic [15:0] writedata;
  logic        waitrequest;

  modport master (
    output chipselect, write, address, writedata,
    input  waitrequest
  );

  modport slave (
    input  chipselect, write, address, writedata,
    output waitrequest
  );
endinterface

// File: rtl/column_frame_scheduler.sv
// Triple-buffer sequencer for raycaster column RAMs: packs 16-bit write pairs into column words
// and rotates display/pending/write roles. Define FRAME_DROP_EN to replace stalling with frame drop.
module column_frame_scheduler #(
  parameter int NUM_COLS = 640,
  parameter int HI_W     = 13,
  parameter int LO_W     = 15,
  parameter int DATA_W   = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  column_frame_scheduler_if.slave avs,
  input  logic                  vblank_start,
  output logic [1:0]            rd_sel,
  output logic [1:0]            wr_sel,
  output logic                  col_we,
  output logic [9:0]            col_waddr,
  output logic [DATA_W-1:0]     col_wdata,
  output logic                  frame_swapped,
  output logic                  frame_committed
`ifdef FRAME_DROP_EN
  ,
  output logic [15:0]           frames_dropped
`endif
);

  typedef enum logic [1:0] {ST_HI, ST_LO, ST_COMMIT, ST_STALL} state_t;

  localparam logic [9:0] LAST_COL = 10'(NUM_COLS - 1);

  state_t              state_reg, state_next;
  logic [1:0]          rd_sel_reg, rd_sel_next;
  logic [1:0]          wr_sel_reg, wr_sel_next;
  logic [1:0]          pend_sel_reg, pend_sel_next;
  logic                pend_valid_reg, pend_valid_next;
  logic [9:0]          col_count_reg, col_count_next;
  logic [HI_W-1:0]     hi_reg, hi_next;
  logic                col_we_reg, col_we_next;
  logic [9:0]          col_waddr_reg, col_waddr_next;
  logic [DATA_W-1:0]   col_wdata_reg, col_wdata_next;
  logic                frame_swapped_reg, frame_swapped_next;
  logic                frame_committed_reg, frame_committed_next;
`ifdef FRAME_DROP_EN
  logic [15:0]         frames_dropped_reg, frames_dropped_next;
`endif

  logic busy;
  logic data_acc;
  logic ctrl_acc;
  logic unused_wdata;

  assign busy         = (state_reg == ST_COMMIT) || (state_reg == ST_STALL);
  assign data_acc     = avs.chipselect && avs.write && !busy && !avs.address;
  assign ctrl_acc     = avs.chipselect && avs.write && !busy && avs.address;
  assign unused_wdata = ^avs.writedata;

  always_comb begin
    state_next           = state_reg;
    rd_sel_next          = rd_sel_reg;
    wr_sel_next          = wr_sel_reg;
    pend_sel_next        = pend_sel_reg;
    pend_valid_next      = pend_valid_reg;
    col_count_next       = col_count_reg;
    hi_next              = hi_reg;
    col_we_next          = 1'b0;
    col_waddr_next       = col_waddr_reg;
    col_wdata_next       = col_wdata_reg;
    frame_swapped_next   = 1'b0;
    frame_committed_next = 1'b0;
`ifdef FRAME_DROP_EN
    frames_dropped_next  = frames_dropped_reg;
`endif

    case (state_reg)
      ST_HI: begin
        if (data_acc) begin
          hi_next    = avs.writedata[HI_W-1:0];
          state_next = ST_LO;
        end else if (ctrl_acc && avs.writedata[0]) begin
          col_count_next = '0;
        end
      end

      ST_LO: begin
        if (data_acc) begin
          col_we_next    = 1'b1;
          col_waddr_next = col_count_reg;
          col_wdata_next = {hi_reg, avs.writedata[LO_W-1:0]};
          // The count parks on the last column until the commit clears it.
          if (col_count_reg == LAST_COL) begin
            state_next = ST_COMMIT;
          end else begin
            col_count_next = col_count_reg + 10'd1;
            state_next     = ST_HI;
          end
        end else if (ctrl_acc && avs.writedata[0]) begin
          col_count_next = '0;
          state_next     = ST_HI;
        end
      end

      ST_COMMIT, ST_STALL: begin
        if (vblank_start && pend_valid_reg) begin
          // Swap and commit in one step: pending goes on screen, the new frame becomes pending.
          rd_sel_next          = pend_sel_reg;
          pend_sel_next        = wr_sel_reg;
          wr_sel_next          = rd_sel_reg;
          frame_swapped_next   = 1'b1;
          frame_committed_next = 1'b1;
          col_count_next       = '0;
          state_next           = ST_HI;
        end else if (state_reg == ST_COMMIT) begin
          if (!pend_valid_reg) begin
            pend_sel_next        = wr_sel_reg;
            wr_sel_next          = 2'b11 ^ rd_sel_reg ^ wr_sel_reg;
            pend_valid_next      = 1'b1;
            frame_committed_next = 1'b1;
            col_count_next       = '0;
            state_next           = ST_HI;
          end else begin
`ifdef FRAME_DROP_EN
            // Newest frame overwrites the pending role; the old pending buffer is refilled.
            pend_sel_next        = wr_sel_reg;
            wr_sel_next          = pend_sel_reg;
            frame_committed_next = 1'b1;
            col_count_next       = '0;
            state_next           = ST_HI;
            if (frames_dropped_reg != 16'hFFFF) begin
              frames_dropped_next = frames_dropped_reg + 16'd1;
            end
`else
            state_next = ST_STALL;
`endif
          end
        end
      end

      default: state_next = ST_HI;
    endcase

    if (!busy && vblank_start && pend_valid_reg) begin
      rd_sel_next        = pend_sel_reg;
      pend_sel_next      = rd_sel_reg;
      pend_valid_next    = 1'b0;
      frame_swapped_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= ST_HI;
      rd_sel_reg          <= 2'd0;
      wr_sel_reg          <= 2'd1;
      pend_sel_reg        <= 2'd2;
      pend_valid_reg      <= 1'b0;
      col_count_reg       <= '0;
      hi_reg              <= '0;
      col_we_reg          <= 1'b0;
      col_waddr_reg       <= '0;
      col_wdata_reg       <= '0;
      frame_swapped_reg   <= 1'b0;
      frame_committed_reg <= 1'b0;
`ifdef FRAME_DROP_EN
      frames_dropped_reg  <= '0;
`endif
    end else begin
      state_reg           <= state_next;
      rd_sel_reg          <= rd_sel_next;
      wr_sel_reg          <= wr_sel_next;
      pend_sel_reg        <= pend_sel_next;
      pend_valid_reg      <= pend_valid_next;
      col_count_reg       <= col_count_next;
      hi_reg              <= hi_next;
      col_we_reg          <= col_we_next;
      col_waddr_reg       <= col_waddr_next;
      col_wdata_reg       <= col_wdata_next;
      frame_swapped_reg   <= frame_swapped_next;
      frame_committed_reg <= frame_committed_next;
`ifdef FRAME_DROP_EN
      frames_dropped_reg  <= frames_dropped_next;
`endif
    end
  end

  assign avs.waitrequest = busy;
  assign rd_sel          = rd_sel_reg;
  assign wr_sel          = wr_sel_reg;
  assign col_we          = col_we_reg;
  assign col_waddr       = col_waddr_reg;
  assign col_wdata       = col_wdata_reg;
  assign frame_swapped   = frame_swapped_reg;
  assign frame_committed = frame_committed_reg;
`ifdef FRAME_DROP_EN
  assign frames_dropped  = frames_dropped_reg;
`endif

endmodule

// File: tb/tb_column_frame_scheduler.sv
// Bench for column_frame_scheduler: directed scenarios plus random traffic checked against
// a rule-level model of buffer roles, column packing and frame events.
module tb_column_frame_scheduler;
  localparam int NUM_COLS = 640;
  localparam int HI_W     = 13;
  localparam int LO_W     = 15;
  localparam int DATA_W   = 28;
`ifdef FRAME_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vblank_start = 1'b0;
  logic [1:0] rd_sel, wr_sel;
  logic col_we;
  logic [9:0] col_waddr;
  logic [DATA_W-1:0] col_wdata;
  logic frame_swapped, frame_committed;
`ifdef FRAME_DROP_EN
  logic [15:0] frames_dropped;
`endif

  column_frame_scheduler_if bus();

  always #10 clk = ~clk;

  column_frame_scheduler #(
    .NUM_COLS(NUM_COLS), .HI_W(HI_W), .LO_W(LO_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs(bus),
    .vblank_start(vblank_start),
    .rd_sel(rd_sel),
    .wr_sel(wr_sel),
    .col_we(col_we),
    .col_waddr(col_waddr),
    .col_wdata(col_wdata),
    .frame_swapped(frame_swapped),
    .frame_committed(frame_committed)
`ifdef FRAME_DROP_EN
    ,
    .frames_dropped(frames_dropped)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Reference model: buffer roles as plain integers, frame progress as a column counter
  // and a "waiting for low half" flag, phase 0 = filling, 1 = frame complete, 2 = held.
  int m_rd, m_wr, m_pend, m_cnt, m_phase, m_dropped;
  bit m_pv, m_half;
  logic [HI_W-1:0] m_hi;
  bit e_we, e_sw, e_cm;
  int e_waddr;
  logic [DATA_W-1:0] e_wdata;

  task automatic model_reset();
    m_rd = 0; m_wr = 1; m_pend = 2; m_pv = 0;
    m_cnt = 0; m_half = 0; m_hi = '0; m_phase = 0; m_dropped = 0;
    e_we = 0; e_sw = 0; e_cm = 0; e_waddr = 0; e_wdata = '0;
  endtask

  task automatic model_step(input bit cs, input bit wrs, input bit addr,
                            input logic [15:0] wd, input bit vb);
    bit acc;
    int old_rd;
    acc  = cs && wrs && (m_phase == 0);
    e_we = 0; e_sw = 0; e_cm = 0;
    if (m_phase == 0) begin
      if (acc && !addr) begin
        if (!m_half) begin
          m_hi   = wd[HI_W-1:0];
          m_half = 1;
        end else begin
          e_we    = 1;
          e_waddr = m_cnt;
          e_wdata = {m_hi, wd[LO_W-1:0]};
          m_half  = 0;
          if (m_cnt == NUM_COLS - 1) m_phase = 1;
          else m_cnt = m_cnt + 1;
        end
      end else if (acc && addr && wd[0]) begin
        m_cnt = 0; m_half = 0;
      end
      if (vb && m_pv) begin
        old_rd = m_rd; m_rd = m_pend; m_pend = old_rd; m_pv = 0; e_sw = 1;
      end
    end else if (vb && m_pv) begin
      old_rd = m_rd; m_rd = m_pend; m_pend = m_wr; m_wr = old_rd;
      e_sw = 1; e_cm = 1; m_cnt = 0; m_phase = 0;
    end else if (m_phase == 1) begin
      if (!m_pv || DROP) begin
        if (m_pv && m_dropped < 65535) m_dropped = m_dropped + 1;
        m_pend = m_wr;
        m_wr   = 3 - m_rd - m_pend;
        m_pv = 1; e_cm = 1; m_cnt = 0; m_phase = 0;
      end else begin
        m_phase = 2;
      end
    end
  endtask

  task automatic step(input bit cs, input bit wrs, input bit addr,
                      input logic [15:0] wd, input bit vb);
    bus.chipselect = cs; bus.write = wrs; bus.address = addr;
    bus.writedata = wd; vblank_start = vb;
    model_step(cs, wrs, addr, wd, vb);
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 1'b0;
    bus.writedata = 16'h0; vblank_start = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic data_write(input logic [15:0] wd);
    step(1'b1, 1'b1, 1'b0, wd, 1'b0);
  endtask

  task automatic write_columns(input int n);
    for (int c = 0; c < n; c++) begin
      data_write(16'($urandom));
      data_write(16'($urandom));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 1'b0;
    bus.writedata = 16'h0; vblank_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_sel !== 2'd0) $display("FAIL reset_rd_sel got=%0d exp=0", rd_sel); else passed++;
    checks++; if (wr_sel !== 2'd1) $display("FAIL reset_wr_sel got=%0d exp=1", wr_sel); else passed++;
    checks++; if (col_we !== 1'b0) $display("FAIL reset_col_we got=%b exp=0", col_we); else passed++;
    checks++; if (col_waddr !== 10'd0) $display("FAIL reset_col_waddr got=%0d exp=0", col_waddr); else passed++;
    checks++; if (col_wdata !== '0) $display("FAIL reset_col_wdata got=%0h exp=0", col_wdata); else passed++;
    checks++; if (bus.waitrequest !== 1'b0) $display("FAIL reset_waitrequest got=%b exp=0", bus.waitrequest); else passed++;
    checks++; if ({frame_swapped, frame_committed} !== 2'b00)
      $display("FAIL reset_pulses got=%b exp=00", {frame_swapped, frame_committed}); else passed++;
`ifdef FRAME_DROP_EN
    checks++; if (frames_dropped !== 16'd0) $display("FAIL reset_frames_dropped got=%0d exp=0", frames_dropped); else passed++;
`endif
    $display("test_reset: rd=%0d wr=%0d", rd_sel, wr_sel);
  endtask

  task automatic test_single_column();
    logic [DATA_W-1:0] exp_word;
    exp_word = {13'h1ABC, 15'h7FFF};
    do_reset();
    data_write(16'h1ABC);
    checks++; if (col_we !== 1'b0) $display("FAIL col_hi_no_we got=%b exp=0", col_we); else passed++;
    data_write(16'h7FFF);
    checks++; if (col_we !== 1'b1) $display("FAIL col_we got=%b exp=1", col_we); else passed++;
    checks++; if (col_waddr !== 10'd0) $display("FAIL col_waddr got=%0d exp=0", col_waddr); else passed++;
    checks++; if (col_wdata !== exp_word) $display("FAIL col_wdata got=%0h exp=%0h", col_wdata, exp_word); else passed++;
    idle();
    checks++; if (col_we !== 1'b0) $display("FAIL col_we_one_cycle got=%b exp=0", col_we); else passed++;
    $display("test_single_column: addr=%0d word=%0h", col_waddr, col_wdata);
  endtask

  task automatic test_frame_commit_swap();
    do_reset();
    write_columns(NUM_COLS);
    checks++; if (col_waddr !== 10'(NUM_COLS - 1)) $display("FAIL last_col_addr got=%0d exp=%0d", col_waddr, NUM_COLS - 1); else passed++;
    checks++; if (bus.waitrequest !== 1'b1) $display("FAIL commit_wait got=%b exp=1", bus.waitrequest); else passed++;
    idle();
    checks++; if (frame_committed !== 1'b1) $display("FAIL committed_pulse got=%b exp=1", frame_committed); else passed++;
    checks++; if (wr_sel !== 2'd2 || rd_sel !== 2'd0)
      $display("FAIL commit_roles got=rd%0d/wr%0d exp=rd0/wr2", rd_sel, wr_sel); else passed++;
    checks++; if (bus.waitrequest !== 1'b0) $display("FAIL commit_release got=%b exp=0", bus.waitrequest); else passed++;
    idle();
    checks++; if (frame_committed !== 1'b0) $display("FAIL committed_one_cycle got=%b exp=0", frame_committed); else passed++;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (rd_sel !== 2'd1 || frame_swapped !== 1'b1)
      $display("FAIL vblank_swap got=rd%0d/sw%b exp=rd1/sw1", rd_sel, frame_swapped); else passed++;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (rd_sel !== 2'd1 || frame_swapped !== 1'b0)
      $display("FAIL vblank_nothing_pending got=rd%0d/sw%b exp=rd1/sw0", rd_sel, frame_swapped); else passed++;
    $display("test_frame_commit_swap: rd=%0d wr=%0d", rd_sel, wr_sel);
  endtask

  task automatic test_two_frames();
    do_reset();
    write_columns(NUM_COLS);
    idle();
    write_columns(NUM_COLS);
    idle();
`ifdef FRAME_DROP_EN
    checks++; if (bus.waitrequest !== 1'b0) $display("FAIL drop_no_stall got=%b exp=0", bus.waitrequest); else passed++;
    checks++; if (frame_committed !== 1'b1) $display("FAIL drop_committed got=%b exp=1", frame_committed); else passed++;
    checks++; if (frames_dropped !== 16'd1) $display("FAIL drop_count got=%0d exp=1", frames_dropped); else passed++;
    checks++; if (wr_sel !== 2'd1) $display("FAIL drop_wr_sel got=%0d exp=1", wr_sel); else passed++;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (rd_sel !== 2'd2 || frame_swapped !== 1'b1)
      $display("FAIL drop_show_newest got=rd%0d/sw%b exp=rd2/sw1", rd_sel, frame_swapped); else passed++;
`else
    repeat (3) idle();
    checks++; if (bus.waitrequest !== 1'b1) $display("FAIL stall_held got=%b exp=1", bus.waitrequest); else passed++;
    data_write(16'h1234);
    data_write(16'h5678);
    checks++; if (col_we !== 1'b0) $display("FAIL stall_blocks_write got=%b exp=0", col_we); else passed++;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (rd_sel !== 2'd1 || wr_sel !== 2'd0)
      $display("FAIL stall_vblank_roles got=rd%0d/wr%0d exp=rd1/wr0", rd_sel, wr_sel); else passed++;
    checks++; if ({frame_swapped, frame_committed} !== 2'b11)
      $display("FAIL stall_vblank_pulses got=%b exp=11", {frame_swapped, frame_committed}); else passed++;
    checks++; if (bus.waitrequest !== 1'b0) $display("FAIL stall_release got=%b exp=0", bus.waitrequest); else passed++;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (rd_sel !== 2'd2) $display("FAIL stall_second_frame_shown got=%0d exp=2", rd_sel); else passed++;
`endif
    $display("test_two_frames: rd=%0d wr=%0d", rd_sel, wr_sel);
  endtask

  task automatic test_coincident_vblank();
    do_reset();
    write_columns(NUM_COLS);
    idle();
    write_columns(NUM_COLS);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (rd_sel !== 2'd1 || wr_sel !== 2'd0)
      $display("FAIL rotate_roles got=rd%0d/wr%0d exp=rd1/wr0", rd_sel, wr_sel); else passed++;
    checks++; if ({frame_swapped, frame_committed} !== 2'b11)
      $display("FAIL rotate_pulses got=%b exp=11", {frame_swapped, frame_committed}); else passed++;
    checks++; if (rd_sel == wr_sel || rd_sel > 2'd2 || wr_sel > 2'd2)
      $display("FAIL rotate_distinct got=rd%0d/wr%0d exp=distinct", rd_sel, wr_sel); else passed++;
    checks++; if (bus.waitrequest !== 1'b0) $display("FAIL rotate_release got=%b exp=0", bus.waitrequest); else passed++;
`ifdef FRAME_DROP_EN
    checks++; if (frames_dropped !== 16'd0) $display("FAIL rotate_no_drop got=%0d exp=0", frames_dropped); else passed++;
`endif
    $display("test_coincident_vblank: rd=%0d wr=%0d", rd_sel, wr_sel);
  endtask

  task automatic test_abort_and_reset();
    logic [DATA_W-1:0] exp_word;
    exp_word = {13'h0AAA, 15'h1234};
    do_reset();
    write_columns(150);
    data_write(16'h0F0F);
    step(1'b1, 1'b1, 1'b1, 16'h0001, 1'b0);
    checks++; if (col_we !== 1'b0) $display("FAIL abort_no_we got=%b exp=0", col_we); else passed++;
    data_write(16'hAAAA);
    checks++; if (col_we !== 1'b0) $display("FAIL abort_hi_half got=%b exp=0", col_we); else passed++;
    data_write(16'h1234);
    checks++; if (col_we !== 1'b1 || col_waddr !== 10'd0)
      $display("FAIL abort_restart got=we%b/addr%0d exp=we1/addr0", col_we, col_waddr); else passed++;
    checks++; if (col_wdata !== exp_word) $display("FAIL abort_word got=%0h exp=%0h", col_wdata, exp_word); else passed++;
    // Move roles away from their reset values before a mid-frame reset.
    write_columns(NUM_COLS - 1);
    idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    write_columns(7);
    data_write(16'h3333);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rd_sel !== 2'd0 || wr_sel !== 2'd1)
      $display("FAIL midreset_roles got=rd%0d/wr%0d exp=rd0/wr1", rd_sel, wr_sel); else passed++;
    checks++; if ({col_we, frame_swapped, frame_committed, bus.waitrequest} !== 4'b0000)
      $display("FAIL midreset_flags got=%b exp=0000", {col_we, frame_swapped, frame_committed, bus.waitrequest}); else passed++;
    checks++; if (col_waddr !== 10'd0 || col_wdata !== '0)
      $display("FAIL midreset_col got=%0d/%0h exp=0/0", col_waddr, col_wdata); else passed++;
    reset = 1'b0;
    model_reset();
    write_columns(1);
    checks++; if (col_we !== 1'b1 || col_waddr !== 10'd0)
      $display("FAIL midreset_restart got=we%b/addr%0d exp=we1/addr0", col_we, col_waddr); else passed++;
    $display("test_abort_and_reset: rd=%0d wr=%0d", rd_sel, wr_sel);
  endtask

  task automatic test_random();
    bit cs, wrs, addr, vb;
    logic [15:0] wd;
    do_reset();
    for (int cyc = 0; cyc < 9000; cyc++) begin
      cs   = ($urandom_range(9) != 0);
      wrs  = ($urandom_range(9) != 0);
      addr = ($urandom_range(1499) == 0);
      wd   = 16'($urandom);
      vb   = ($urandom_range(399) == 0);
      step(cs, wrs, addr, wd, vb);
      checks++; if (col_we !== e_we) $display("FAIL rnd_col_we cyc=%0d got=%b exp=%b", cyc, col_we, e_we); else passed++;
      if (e_we) begin
        checks++; if (col_waddr !== 10'(e_waddr))
          $display("FAIL rnd_col_waddr cyc=%0d got=%0d exp=%0d", cyc, col_waddr, e_waddr); else passed++;
        checks++; if (col_wdata !== e_wdata)
          $display("FAIL rnd_col_wdata cyc=%0d got=%0h exp=%0h", cyc, col_wdata, e_wdata); else passed++;
      end
      checks++; if (rd_sel !== 2'(m_rd) || wr_sel !== 2'(m_wr))
        $display("FAIL rnd_roles cyc=%0d got=rd%0d/wr%0d exp=rd%0d/wr%0d", cyc, rd_sel, wr_sel, m_rd, m_wr); else passed++;
      checks++; if (bus.waitrequest !== (m_phase != 0))
        $display("FAIL rnd_waitrequest cyc=%0d got=%b exp=%b", cyc, bus.waitrequest, m_phase != 0); else passed++;
      checks++; if (frame_swapped !== e_sw || frame_committed !== e_cm)
        $display("FAIL rnd_pulses cyc=%0d got=%b%b exp=%b%b", cyc, frame_swapped, frame_committed, e_sw, e_cm); else passed++;
`ifdef FRAME_DROP_EN
      checks++; if (frames_dropped !== 16'(m_dropped))
        $display("FAIL rnd_frames_dropped cyc=%0d got=%0d exp=%0d", cyc, frames_dropped, m_dropped); else passed++;
`endif
      if (e_sw || e_cm)
        $display("rnd cyc=%0d commit=%0b swap=%0b rd=%0d wr=%0d", cyc, e_cm, e_sw, m_rd, m_wr);
    end
    $display("test_random: rd=%0d wr=%0d", rd_sel, wr_sel);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 1'b0; bus.writedata = 16'h0;
    model_reset();
    test_reset();
    test_single_column();
    test_frame_commit_swap();
    test_two_frames();
    test_coincident_vblank();
    test_abort_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
